// File: rtl/uart_rx_deserializer_if.sv
// Output-side handshake bundle of the UART receiver.
//   data        received word, valid while data_valid=1
//   data_valid  holding register full
//   data_ready  consumer accepts the word when data_valid & data_ready
//   parity_err  parity mismatch of the held word
//   frame_err   a stop bit of the held word was sampled low
//   overrun     one-cycle pulse: a completed frame was dropped
// master: the receiver; slave: the consumer.
interface uart_rx_deserializer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data, data_valid, parity_err, frame_err, overrun,
    input  data_ready
  );

  modport slave (
    input  data, data_valid, parity_err, frame_err, overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Self-timed UART receive datapath: synchronises rx, detects the start
// bit, samples every bit at mid-period from an internal baud counter and
// presents the assembled word on a valid/ready holding register.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   rx        asynchronous serial input, idle high
//   rx_en     receiver enable; gates acceptance of new start bits only
//   out_if    word, valid/ready handshake, parity/frame/overrun status
//   busy      high whenever the receiver is not idle
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned LSB_FIRST    = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx,
  input  logic                    rx_en,
  uart_rx_deserializer_if.master  out_if,
  output logic                    busy
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_s_prev;
  logic                   start_edge;
  logic                   sample;
  logic [BAUD_W-1:0]      baud;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_err_r;
  logic                   frame_err_r;
  logic                   complete;
  logic                   can_load;

  assign rx_s       = sync[SYNC_STAGES-1];
  assign start_edge = rx_s_prev & ~rx_s;
  assign sample     = (baud == '0);
  // Final stop sample: the word is handed over at the end of this cycle,
  // so the last stop bit's level is folded in directly below.
  assign complete   = (state == STOP) && sample && (bit_cnt == CNT_W'(STOP_BITS - 1));
  assign can_load   = ~out_if.data_valid | out_if.data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '1;
      rx_s_prev <= 1'b1;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], rx};
      rx_s_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      baud        <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par_err_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (state != IDLE)
        baud <= sample ? BAUD_W'(CLKS_PER_BIT - 1) : baud - 1'b1;
      case (state)
        IDLE: begin
          if (start_edge && rx_en) begin
            state       <= START;
            baud        <= BAUD_W'(CLKS_PER_BIT / 2 - 1);
            busy        <= 1'b1;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
          end
        end
        START: begin
          if (sample) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (sample) begin
            if (LSB_FIRST != 0)
              shift <= {rx_s, shift[DATA_BITS-1:1]};
            else
              shift <= {shift[DATA_BITS-2:0], rx_s};
            if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample) begin
            par_err_r <= ^shift ^ rx_s ^ 1'(PARITY_ODD);
            state     <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            if (!rx_s)
              frame_err_r <= 1'b1;
            if (complete) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_if.data       <= '0;
      out_if.data_valid <= 1'b0;
      out_if.parity_err <= 1'b0;
      out_if.frame_err  <= 1'b0;
      out_if.overrun    <= 1'b0;
    end else begin
      out_if.overrun <= complete & ~can_load;
      if (complete && can_load) begin
        out_if.data       <= shift;
        out_if.data_valid <= 1'b1;
        out_if.parity_err <= par_err_r;
        out_if.frame_err  <= frame_err_r | ~rx_s;
      end else if (out_if.data_valid && out_if.data_ready) begin
        out_if.data_valid <= 1'b0;
      end
    end
  end

endmodule
